// File: rtl/mem_arbiter.sv
// Memory arbiter: serializes instruction-fetch and data requests onto a single-ported RAM.
// Data requests win over fetches; hits and the error flag are decoded from state only.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] imemload,
  output logic [31:0] dmemload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  typedef enum logic [2:0] {
    StIdle,
    StIacc,
    StDacc,
    StIdone,
    StDdone,
    StErr
  } state_e;

  localparam logic [1:0] RamAccess  = 2'd2;
  localparam logic [1:0] RamError   = 2'd3;
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic        wr_q, wr_d;
  logic [31:0] imemload_q, imemload_d;
  logic [31:0] dmemload_q, dmemload_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      store_q    <= '0;
      wr_q       <= 1'b0;
      imemload_q <= '0;
      dmemload_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      store_q    <= store_d;
      wr_q       <= wr_d;
      imemload_q <= imemload_d;
      dmemload_q <= dmemload_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    store_d    = store_q;
    wr_d       = wr_q;
    imemload_d = imemload_q;
    dmemload_d = dmemload_q;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (dmemREN || dmemWEN) begin
          state_d = StDacc;
          addr_d  = dmemaddr;
          store_d = dmemstore;
          wr_d    = dmemWEN;
        end else if (imemREN) begin
          state_d = StIacc;
          addr_d  = imemaddr;
          wr_d    = 1'b0;
        end
      end

      StIacc, StDacc: begin
        // Saturating counter: a stuck RAM must never wrap back under the timeout.
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        if (ramstate == RamError) begin
          state_d = StErr;
        end else if (ramstate == RamAccess) begin
          if (state_q == StIacc) begin
            imemload_d = ramload;
            state_d    = StIdone;
          end else begin
            if (!wr_q) begin
              dmemload_d = ramload;
            end
            state_d = StDdone;
          end
        end else if (cnt_d >= TimeoutCnt) begin
          state_d = StErr;
        end
      end

      StIdone, StDdone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end

      StErr: state_d = StErr;

      default: state_d = StIdle;
    endcase
  end

  logic in_acc;
  assign in_acc = (state_q == StIacc) || (state_q == StDacc);

  assign ihit     = (state_q == StIdone);
  assign dhit     = (state_q == StDdone);
  assign memerr   = (state_q == StErr);
  assign ramREN   = (state_q == StIacc) || ((state_q == StDacc) && !wr_q);
  assign ramWEN   = (state_q == StDacc) && wr_q;
  assign ramaddr  = in_acc ? addr_q : '0;
  assign ramstore = ramWEN ? store_q : '0;
  assign imemload = imemload_q;
  assign dmemload = dmemload_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses push expected hits; a negedge monitor
// pops and compares on every ihit/dhit.
module tb_mem_arbiter;

  localparam logic [1:0] RFree   = 2'd0;
  localparam logic [1:0] RBusy   = 2'd1;
  localparam logic [1:0] RAccess = 2'd2;
  localparam logic [1:0] RError  = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN, dmemREN, dmemWEN;
  logic [31:0] imemaddr, dmemaddr, dmemstore;
  logic        ihit, dhit, ramREN, ramWEN, memerr;
  logic [31:0] imemload, dmemload, ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  mem_arbiter #(.TIMEOUT(15)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ihit(ihit), .dhit(dhit), .imemload(imemload), .dmemload(dmemload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_imem = '0;
  logic [31:0] exp_dmem = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (nRST && (ihit || dhit)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_hit: ihit=%0b dhit=%0b with empty scoreboard at %0t",
                 ihit, dhit, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("hit_kind_dhit", {31'd0, dhit}, {31'd0, e.is_d});
        chk("hit_kind_ihit", {31'd0, ihit}, {31'd0, ~e.is_d});
        chk(e.is_d ? "dmemload" : "imemload", e.is_d ? dmemload : imemload, e.data);
      end
    end
  end

  // One full access: IDLE cycle, `busy` BUSY cycles, one ACCESS cycle, then the hit cycle.
  task automatic access(input logic is_d, input logic wen, input logic ren,
                        input logic [31:0] addr, input logic [31:0] store,
                        input int busy, input logic [31:0] load);
    logic wr;
    exp_t e;
    wr = is_d && wen;
    if (is_d) begin
      dmemREN = ren; dmemWEN = wen; dmemaddr = addr; dmemstore = store;
    end else begin
      imemREN = 1'b1; imemaddr = addr;
    end
    if (!is_d) exp_imem = load;
    else if (!wr) exp_dmem = load;
    e.is_d = is_d;
    e.data = is_d ? exp_dmem : exp_imem;
    exp_q.push_back(e);
    chk("idle_no_strobe", {30'd0, ramREN, ramWEN}, 32'd0);
    tick();
    for (int c = 0; c <= busy; c++) begin
      ramstate = (c == busy) ? RAccess : RBusy;
      ramload  = (c == busy) ? load : 32'hBAD0_0000 + c;
      chk("acc_ramREN", {31'd0, ramREN}, {31'd0, ~wr});
      chk("acc_ramWEN", {31'd0, ramWEN}, {31'd0, wr});
      chk("acc_ramaddr", ramaddr, addr);
      if (wr) chk("acc_ramstore", ramstore, store);
      chk("acc_no_hit", {30'd0, ihit, dhit}, 32'd0);
      tick();
    end
    ramstate = RFree;
    chk(is_d ? "dhit_on_time" : "ihit_on_time", {31'd0, is_d ? dhit : ihit}, 32'd1);
    chk("done_no_strobe", {30'd0, ramREN, ramWEN}, 32'd0);
    imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    exp_imem = '0;
    exp_dmem = '0;
    tick();
    nRST = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0;
    imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    imemaddr = '0; dmemaddr = '0; dmemstore = '0;
    ramload = '0; ramstate = RFree;
    #2;
    chk("rst_strobes", {27'd0, ihit, dhit, ramREN, ramWEN, memerr}, 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    chk("rst_dmemload", dmemload, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    tick();
    nRST = 1'b1;
    tick();

    // Reset in the middle of a data write.
    dmemWEN = 1'b1; dmemaddr = 32'h0000_0080; dmemstore = 32'h1111_2222;
    tick();
    ramstate = RBusy;
    chk("midwr_ramWEN", {31'd0, ramWEN}, 32'd1);
    #1;
    nRST = 1'b0;
    #1;
    chk("midwr_rst_out", {29'd0, ramWEN, dhit, memerr}, 32'd0);
    dmemWEN = 1'b0;
    ramstate = RFree;
    tick();
    nRST = 1'b1;
    tick();
    chk("midwr_idle", {27'd0, ihit, dhit, ramREN, ramWEN, memerr}, 32'd0);
    tick();
    chk("midwr_still_idle", {30'd0, ramREN, ramWEN}, 32'd0);

    // Fetch with two BUSY cycles.
    access(1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'd0, 2, 32'h2402_0005);
    chk("imemload_kept", imemload, 32'h2402_0005);

    // Simultaneous fetch and data read: data first, fetch three cycles after dhit.
    begin
      exp_t e;
      imemREN = 1'b1; imemaddr = 32'h0000_0044;
      dmemREN = 1'b1; dmemaddr = 32'h0000_0100;
      exp_dmem = 32'h1234_5678;
      exp_imem = 32'h8C22_0004;
      e.is_d = 1'b1; e.data = exp_dmem; exp_q.push_back(e);
      e.is_d = 1'b0; e.data = exp_imem; exp_q.push_back(e);
      tick();
      ramstate = RAccess; ramload = 32'h1234_5678;
      chk("sim_d_ramaddr", ramaddr, 32'h0000_0100);
      chk("sim_d_ramREN", {31'd0, ramREN}, 32'd1);
      tick();
      ramstate = RFree;
      chk("sim_dhit", {30'd0, ihit, dhit}, 32'd1);
      dmemREN = 1'b0;
      tick();
      chk("sim_gap1", {30'd0, ihit, dhit}, 32'd0);
      tick();
      ramstate = RAccess; ramload = 32'h8C22_0004;
      chk("sim_i_ramaddr", ramaddr, 32'h0000_0044);
      chk("sim_gap2", {30'd0, ihit, dhit}, 32'd0);
      tick();
      ramstate = RFree;
      chk("sim_ihit", {30'd0, ihit, dhit}, 32'd2);
      imemREN = 1'b0;
      tick();
      chk("sim_after", {30'd0, ihit, dhit}, 32'd0);
    end

    // Data write: dmemload keeps the earlier read value.
    access(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'hDEAD_BEEF, 1, 32'hFFFF_0000);
    chk("wr_dmemload_kept", dmemload, 32'h1234_5678);

    // REN and WEN together: write wins.
    access(1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h0BAD_F00D, 0, 32'h5555_AAAA);

    // A data read after the writes.
    access(1'b1, 1'b0, 1'b1, 32'h0000_0304, 32'd0, 0, 32'hCAFE_0001);

    // Timeout: 15 BUSY cycles send the arbiter to ERR.
    imemREN = 1'b1; imemaddr = 32'h0000_0050;
    tick();
    ramstate = RBusy;
    for (int c = 0; c < 15; c++) begin
      chk("to_memerr_low", {31'd0, memerr}, 32'd0);
      chk("to_ramREN", {31'd0, ramREN}, 32'd1);
      tick();
    end
    chk("to_memerr", {31'd0, memerr}, 32'd1);
    chk("to_ramREN_off", {31'd0, ramREN}, 32'd0);
    ramstate = RAccess; ramload = 32'h7777_7777;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("to_sticky", {27'd0, memerr, ihit, dhit, ramREN, ramWEN}, 32'h10);
    end
    chk("to_imemload", imemload, 32'h8C22_0004);
    imemREN = 1'b0; ramstate = RFree;
    do_reset();
    chk("to_rst_memerr", {31'd0, memerr}, 32'd0);
    chk("to_rst_imemload", imemload, 32'd0);

    // RAM ERROR on the first DACC cycle.
    dmemREN = 1'b1; dmemaddr = 32'h0000_0400;
    tick();
    ramstate = RError;
    chk("err_acc_ren", {31'd0, ramREN}, 32'd1);
    tick();
    ramstate = RAccess;
    chk("err_memerr", {31'd0, memerr}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("err_no_dhit", {27'd0, memerr, ihit, dhit, ramREN, ramWEN}, 32'h10);
    end
    dmemREN = 1'b0; ramstate = RFree;
    do_reset();

    // Recovery after reset: a normal fetch works again.
    access(1'b0, 1'b0, 1'b0, 32'h0000_0060, 32'd0, 0, 32'h0000_ABCD);
    tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder side of the pipeline's memory request interface.
- Accepts instruction-fetch and data read/write requests from the datapath and serializes them onto the single-ported RAM.
- Returns the ihit/dhit completion pulses that the hazard unit uses to gate the PC and pipeline registers.
- Sits between the datapath/hazard unit and the RAM model; data requests take priority over instruction fetch.

Parameters:
TIMEOUT, 15, max cycles an access may wait for ramstate==ACCESS before entering the error state (range 1..255)

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
imemREN  input  1  instruction fetch request, level, held until ihit
imemaddr  input  32  instruction word address
dmemREN  input  1  data read request, level, held until dhit
dmemWEN  input  1  data write request, level, held until dhit
dmemaddr  input  32  data word address
dmemstore  input  32  data write value
ihit  output  1  one-cycle pulse: fetch complete, imemload valid
dhit  output  1  one-cycle pulse: data access complete, dmemload valid on reads
imemload  output  32  fetched instruction, registered
dmemload  output  32  loaded data, registered
ramREN  output  1  RAM read strobe
ramWEN  output  1  RAM write strobe
ramaddr  output  32  RAM address
ramstore  output  32  RAM write data
ramload  input  32  RAM read data, valid when ramstate==ACCESS
ramstate  input  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
memerr  output  1  sticky error flag

Behaviour:
- Reset (nRST low, asynchronous):
  - state=IDLE; all outputs 0.
  - imemload, dmemload, timeout counter and latched request registers cleared.
- States: IDLE, IACC, DACC, IDONE, DDONE, ERR.
- IDLE:
  - dmemREN|dmemWEN -> DACC; latch dmemaddr, dmemstore, op. dmemWEN wins if both REN and WEN are set.
  - else imemREN -> IACC; latch imemaddr.
  - else stay. No RAM strobes in IDLE.
- Simultaneous instruction and data requests: data is served first; the fetch is served on the next IDLE visit.
- IACC/DACC:
  - ramaddr/ramstore driven from latched values.
  - ramREN=1 for IACC or a data read; ramWEN=1 for a data write.
  - Counter increments each cycle. On the edge where ramstate==ACCESS:
    - IACC: imemload<=ramload, go to IDONE.
    - DACC read: dmemload<=ramload, go to DDONE.
    - DACC write: go to DDONE; dmemload unchanged.
- IDONE/DDONE:
  - ihit/dhit=1 for exactly this one cycle; strobes low.
  - Counter cleared; next state IDLE.
  - Minimum request-to-hit latency: 3 cycles (IDLE, ACC with ACCESS, DONE).
- Request deasserted mid-access: the access completes and the hit still pulses. The requester ignores it.
- Request inputs are sampled only in IDLE. Changes during ACC/DONE are ignored until the next IDLE.
- ERR entry: ramstate==ERROR in an ACC state, or the counter reaching TIMEOUT without ACCESS.
- ERR:
  - memerr=1, all strobes 0, no hits ever.
  - Exit only by reset.
- Counter is 8 bits and saturates; it never wraps.
- Back-to-back requests: a request held high after IDLE->DONE is re-served. The datapath must drop or advance its request on the hit cycle.
- Outputs ihit, dhit and memerr are decoded from state only (Moore); no combinational path from request inputs to hits.

Test Plan:
- Reset mid-DACC write (ramWEN=1), nRST low -> ramWEN, dhit and memerr 0 immediately; state IDLE after release.
- imemREN=1, imemaddr=0x0000_0040, ramstate BUSY for 2 cycles then ACCESS with ramload=0x2402_0005:
  - ramREN=1 and ramaddr=0x40 during access.
  - ihit pulses once 4 cycles after the request.
  - imemload=0x2402_0005.
- imemREN=1 and dmemREN=1 together, dmemaddr=0x100, both RAM accesses 1-cycle ACCESS:
  - dhit pulses first with ramaddr=0x100.
  - ihit follows 3 cycles later.
  - Exactly one pulse each.
- dmemWEN=1, dmemaddr=0x200, dmemstore=0xDEAD_BEEF -> ramWEN=1, ramstore=0xDEADBEEF during access; dhit pulses; dmemload keeps its prior value.
- TIMEOUT=15, ramstate held BUSY:
  - After 15 ACC cycles, memerr=1 and ramREN=0.
  - No ihit or dhit thereafter.
  - Later ramstate==ACCESS has no effect until reset.
- ramstate=ERROR on the first DACC cycle -> memerr=1 next cycle; dhit never asserts.
